// File: rtl/pc_unit_if.sv
// Request and status bundle between the branch-resolution logic and the PC unit.
// The master side issues stalls and redirects; the PC unit is the slave.
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             busywait;
    logic             redirect;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] redirect_target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_seq;
    logic             redirect_pending;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_overflow;
    logic             ras_underflow;

    modport master (
        output busywait, redirect, call, ret, redirect_target,
        input  pc, pc_seq, redirect_pending, ras_empty, ras_full,
               ras_overflow, ras_underflow
    );

    modport slave (
        input  busywait, redirect, call, ret, redirect_target,
        output pc, pc_seq, redirect_pending, ras_empty, ras_full,
               ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter with a circular return-address stack and a single pending-redirect
// slot that remembers the latest request seen while memory stalls.
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'hFFFF_FFFC,
    parameter int               INC          = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input logic     clk,
    input logic     reset,
    pc_unit_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_REDIRECT,
        REQ_CALL,
        REQ_RET
    } req_e;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_next_seq;
    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W:0]   count;
    logic             pend_valid;
    req_e             pend_kind;
    logic [WIDTH-1:0] pend_target;
    logic             overflow_q;
    logic             underflow_q;

    req_e             live_kind;
    req_e             commit_kind;
    logic [WIDTH-1:0] commit_target;
    logic [WIDTH-1:0] stack_top;
    logic             stack_is_empty;
    logic             stack_is_full;

    assign pc_next_seq    = pc_q + WIDTH'(INC);
    assign stack_top      = stack[ptr - PTR_W'(1)];
    assign stack_is_empty = (count == '0);
    assign stack_is_full  = (count == (PTR_W+1)'(RAS_DEPTH));

    // A live request always wins over whatever was captured during an earlier stall.
    always_comb begin
        live_kind = REQ_NONE;
        if (bus.ret)
            live_kind = REQ_RET;
        else if (bus.call)
            live_kind = REQ_CALL;
        else if (bus.redirect)
            live_kind = REQ_REDIRECT;

        commit_kind   = REQ_NONE;
        commit_target = bus.redirect_target;
        if (live_kind != REQ_NONE) begin
            commit_kind   = live_kind;
            commit_target = bus.redirect_target;
        end else if (pend_valid) begin
            commit_kind   = pend_kind;
            commit_target = pend_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            ptr         <= '0;
            count       <= '0;
            pend_valid  <= 1'b0;
            pend_kind   <= REQ_NONE;
            pend_target <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.busywait) begin
            if (live_kind != REQ_NONE) begin
                pend_valid  <= 1'b1;
                pend_kind   <= live_kind;
                pend_target <= bus.redirect_target;
            end
        end else begin
            pend_valid <= 1'b0;
            case (commit_kind)
                REQ_RET: begin
                    if (!stack_is_empty) begin
                        pc_q  <= stack_top;
                        ptr   <= ptr - PTR_W'(1);
                        count <= count - (PTR_W+1)'(1);
                    end else begin
                        pc_q        <= pc_next_seq;
                        underflow_q <= 1'b1;
                    end
                end
                // When full the write pointer already sits on the oldest entry.
                REQ_CALL: begin
                    pc_q <= commit_target;
                    ptr  <= ptr + PTR_W'(1);
                    if (stack_is_full)
                        overflow_q <= 1'b1;
                    else
                        count <= count + (PTR_W+1)'(1);
                end
                REQ_REDIRECT: pc_q <= commit_target;
                default:      pc_q <= pc_next_seq;
            endcase
        end
    end

    // Stack storage needs no reset; the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && !bus.busywait && commit_kind == REQ_CALL)
            stack[ptr] <= pc_next_seq;
    end

    assign bus.pc               = pc_q;
    assign bus.pc_seq           = pc_next_seq;
    assign bus.redirect_pending = pend_valid;
    assign bus.ras_empty        = stack_is_empty;
    assign bus.ras_full         = stack_is_full;
    assign bus.ras_overflow     = overflow_q;
    assign bus.ras_underflow    = underflow_q;
endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes the expected post-edge state from a
// queue-based reference model, and a monitor pops and compares after every clock edge.
module tb_pc_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic clk;
    logic reset;
    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(
        .WIDTH(32), .RESET_VECTOR(RV), .INC(4), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    bit          done     = 0;

    // Reference model state: the return stack is a plain queue, newest at the back.
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_pend;
    int          m_pend_kind;
    logic [31:0] m_pend_tgt;
    logic        m_ovf;
    logic        m_unf;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // kind: 0 none, 1 redirect, 2 call, 3 ret
    task automatic modelCommit(input int kind, input logic [31:0] tgt);
        case (kind)
            3: begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else begin
                    m_pc  = m_pc + 32'd4;
                    m_unf = 1'b1;
                end
            end
            2: begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_pc = tgt;
            end
            1:       m_pc = tgt;
            default: m_pc = m_pc + 32'd4;
        endcase
    endtask

    task automatic applyStimulus(input logic rst, input logic busy, input logic redir,
                                 input logic call, input logic ret, input logic [31:0] tgt);
        int   live;
        exp_t e;
        @(negedge clk);
        reset               = rst;
        bus.busywait        = busy;
        bus.redirect        = redir;
        bus.call            = call;
        bus.ret             = ret;
        bus.redirect_target = tgt;
        live = ret ? 3 : call ? 2 : redir ? 1 : 0;
        if (rst) begin
            m_pc   = RV;
            m_ras.delete();
            m_pend = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else if (busy) begin
            if (live != 0) begin
                m_pend      = 1'b1;
                m_pend_kind = live;
                m_pend_tgt  = tgt;
            end
        end else begin
            if (live != 0)   modelCommit(live, tgt);
            else if (m_pend) modelCommit(m_pend_kind, m_pend_tgt);
            else             modelCommit(0, tgt);
            m_pend = 1'b0;
        end
        e.pc    = m_pc;
        e.pend  = m_pend;
        e.empty = (m_ras.size() == 0);
        e.full  = (m_ras.size() == DEPTH);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic jump(input logic [31:0] tgt);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, tgt);
    endtask

    // Monitor: every edge that has an outstanding expectation is compared field by field.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("pc",               bus.pc,                       e.pc);
                checkOutput("pc_seq",           bus.pc_seq,                   e.pc + 32'd4);
                checkOutput("redirect_pending", {31'b0, bus.redirect_pending}, {31'b0, e.pend});
                checkOutput("ras_empty",        {31'b0, bus.ras_empty},        {31'b0, e.empty});
                checkOutput("ras_full",         {31'b0, bus.ras_full},         {31'b0, e.full});
                checkOutput("ras_overflow",     {31'b0, bus.ras_overflow},     {31'b0, e.ovf});
                checkOutput("ras_underflow",    {31'b0, bus.ras_underflow},    {31'b0, e.unf});
            end
        end
    end

    initial begin
        reset               = 1'b1;
        bus.busywait        = 1'b0;
        bus.redirect        = 1'b0;
        bus.call            = 1'b0;
        bus.ret             = 1'b0;
        bus.redirect_target = 32'h0;
        m_pc = RV; m_pend = 1'b0; m_pend_kind = 0; m_pend_tgt = 32'h0;
        m_ovf = 1'b0; m_unf = 1'b0;

        // Reset then free-running sequential fetch through the wrap at zero.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(3);

        jump(32'h0000_0010);
        jump(32'h0000_0100);
        idle(1);

        // Redirect captured during a stall survives until the stall ends.
        jump(32'h0000_0020);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0200);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(2);

        jump(32'h0000_0030);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0400);
        idle(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

        // Overfill then drain the return stack past empty.
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1000 * (i + 1));
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

        // Wrap, then reset in the middle of a stall with a captured request.
        jump(32'hFFFF_FFFC);
        idle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0800);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0900);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(2);

        // Captured call and ret committing after a stall, and overwrite by a later request.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0A00);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0B00);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0C00);
        idle(1);

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 35,
                          $urandom_range(0, 99) < 20,
                          $urandom_range(0, 99) < 20,
                          $urandom_range(0, 99) < 18,
                          $urandom());
        end
        idle(1);

        @(posedge clk);
        #2;
        done = 1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
